mutex_lock_sequencer: RTL

- Arbitrates NUM_REQ local requesters for one hardware mutex peripheral (2-word Avalon-MM slave: word 0 = {owner[31:16], value[15:0]}, word 1 = reset flag).
- Runs the init, acquire (write then verify), retry/backoff and release sequences on the mutex slave port.
- Hands each requester a level grant, so accelerator/fingerprint logic can take a lock without CPU polling.
- Sits between local hardware masters and the mutex slave, in the same Avalon fabric as the CPUs that share the mutex.

---
 rtl/mutex_pkg.sv | 33 +++
 rtl/rr_pick.sv | 33 +++
 rtl/mutex_lock_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mutex_pkg.sv
// rtl/mutex_pkg.sv - shared types and constants for the hardware mutex sequencer
//
// Purpose: sequencer state encoding, mutex slave word map and word packing helper.
// Ports:   none (package).
package mutex_pkg;

  localparam int OWNER_W = 16;
  localparam int VALUE_W = 16;
  localparam int WORD_W  = OWNER_W + VALUE_W;

  // Mutex slave word select: word 0 holds {owner, value}, word 1 the reset flag.
  localparam logic MUTEX_ADDR_STATE = 1'b0;
  localparam logic MUTEX_ADDR_RESET = 1'b1;

  // Writing a one to bit 0 of the reset word clears the flag.
  localparam logic [WORD_W-1:0] RESET_FLAG_CLEAR = 32'h0000_0001;

  typedef enum logic [2:0] {
    INIT_RD,
    INIT_CLR,
    IDLE,
    TRY_WR,
    TRY_RD,
    BACKOFF,
    REL_WR
  } state_t;

  function automatic logic [WORD_W-1:0] mutex_word(input logic [OWNER_W-1:0] owner,
                                                   input logic [VALUE_W-1:0] value);
    return {owner, value};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set finder
//
// Purpose: returns the first set bit of req at or after ptr, wrapping around.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  search start index (must be < N)
//   idx   out IW  index of the selected request
//   valid out 1   at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mutex_lock_sequencer.sv
// rtl/mutex_lock_sequencer.sv - hardware requester front end for an Avalon mutex slave
//
// Purpose: clears the mutex reset flag, then arbitrates NUM_REQ local requesters
//          round robin, acquiring the mutex by write-then-verify, backing off on
//          contention, and releasing it on behalf of the holder.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req[NUM_REQ]        level request per requester
//   rel[NUM_REQ]        one-cycle release pulse from the holder
//   grant[NUM_REQ]      one-hot lock-held indication
//   init_done           mutex reset flag has been cleared
//   m_address, m_chipselect, m_read, m_write, m_writedata, m_readdata
//                       Avalon-MM master to the mutex slave (zero wait states)
module mutex_lock_sequencer
  import mutex_pkg::*;
#(
  parameter int             NUM_REQ    = 4,
  parameter logic [15:0]    OWNER_BASE = 16'h0100,
  parameter logic [15:0]    LOCK_VALUE = 16'h0001,
  parameter int             RETRY_WAIT = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  output logic [NUM_REQ-1:0] grant,
  output logic               init_done,
  output logic               m_address,
  output logic               m_chipselect,
  output logic               m_read,
  output logic               m_write,
  output logic [31:0]        m_writedata,
  input  logic [31:0]        m_readdata
);

  localparam int          IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] BACKOFF_LOAD = 16'(RETRY_WAIT);

  state_t               state_q, state_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        cur_q, cur_d;
  logic [15:0]          boff_q, boff_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 init_done_q, init_done_d;
  logic                 addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [31:0]          wdata_q, wdata_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  logic [NUM_REQ-1:0]   cur_onehot;
  logic [OWNER_W-1:0]   cur_owner;
  logic [OWNER_W-1:0]   pick_owner;
  logic [IW-1:0]        cur_next;
  logic                 holder_done;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cur_onehot[k] = (cur_q == IW'(k));
    end
  end

  assign cur_owner  = OWNER_BASE + 16'(cur_q);
  assign pick_owner = OWNER_BASE + 16'(pick_idx);
  assign cur_next   = (cur_q == IW'(NUM_REQ - 1)) ? '0 : cur_q + IW'(1);

  // cur_q keeps naming the holder for the whole time a grant is up, so the
  // release check only looks at that requester; rel from anyone else is ignored.
  assign holder_done = (grant_q != '0) && (rel[cur_q] || !req[cur_q]);

  // Next-state and next-output logic. Bus outputs are decoded for the state
  // being entered, so the registered strobes line up with the state they serve.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cur_d       = cur_q;
    boff_d      = boff_q;
    grant_d     = grant_q;
    init_done_d = init_done_q;
    addr_d      = MUTEX_ADDR_STATE;
    cs_d        = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    wdata_d     = '0;

    case (state_q)
      INIT_RD: begin
        // The first cycle after reset only launches the read; the data is
        // sampled in the cycle the read strobe is actually on the bus.
        if (!rd_q) begin
          cs_d   = 1'b1;
          rd_d   = 1'b1;
          addr_d = MUTEX_ADDR_RESET;
        end else if (m_readdata[0]) begin
          state_d = INIT_CLR;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = MUTEX_ADDR_RESET;
          wdata_d = RESET_FLAG_CLEAR;
        end else begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end

      INIT_CLR: begin
        state_d     = IDLE;
        init_done_d = 1'b1;
      end

      IDLE: begin
        // Release has priority so a pending release always completes before
        // another requester's TRY_WR reaches the bus.
        if (holder_done) begin
          state_d = REL_WR;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          wdata_d = mutex_word(cur_owner, '0);
        end else if (init_done_q && grant_q == '0 && pick_valid) begin
          state_d = TRY_WR;
          cur_d   = pick_idx;
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          wdata_d = mutex_word(pick_owner, LOCK_VALUE);
        end
      end

      TRY_WR: begin
        state_d = TRY_RD;
        cs_d    = 1'b1;
        rd_d    = 1'b1;
      end

      TRY_RD: begin
        rr_d = cur_next;
        if (m_readdata == mutex_word(cur_owner, LOCK_VALUE)) begin
          grant_d = cur_onehot;
          state_d = IDLE;
        end else begin
          boff_d  = BACKOFF_LOAD;
          state_d = BACKOFF;
        end
      end

      BACKOFF: begin
        if (boff_q <= 16'd1) begin
          boff_d  = '0;
          state_d = IDLE;
        end else begin
          boff_d = boff_q - 16'd1;
        end
      end

      REL_WR: begin
        grant_d = '0;
        state_d = IDLE;
      end

      default: state_d = INIT_RD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT_RD;
      rr_q        <= '0;
      cur_q       <= '0;
      boff_q      <= '0;
      grant_q     <= '0;
      init_done_q <= 1'b0;
      addr_q      <= 1'b0;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cur_q       <= cur_d;
      boff_q      <= boff_d;
      grant_q     <= grant_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign grant        = grant_q;
  assign init_done    = init_done_q;
  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_read       = rd_q;
  assign m_write      = wr_q;
  assign m_writedata  = wdata_q;

endmodule
